cla_pg_stage: RTL and testbench

Registered propagate/generate front-end for the 5-bit carry-lookahead adder. It accepts operand pairs plus carry-in over a valid/ready handshake. It computes bitwise propagate and inverted generate, and holds the results in a 2-entry output buffer. The carry lookahead logic sits directly downstream and consumes `p`, `g_bar` and `c0`; the sum XOR stage uses the same `p`.

---
 rtl/cla_pg_stage.sv | 126 ++++++++++++
 tb/tb_cla_pg_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cla_pg_stage.sv
// rtl/cla_pg_stage.sv - registered propagate/generate front-end with 2-entry output buffer
module cla_pg_stage #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] g_bar,
  output logic             c0,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             push, pop;
  logic             load_head_new, load_tail_new, load_head_from_tail;
  logic [WIDTH-1:0] p_new, g_bar_new;
  logic [WIDTH-1:0] head_p, head_g_bar, tail_p, tail_g_bar;
  logic             head_c0, tail_c0;

  assign p_new     = a ^ b;
  assign g_bar_new = ~(a & b);

  // in_ready depends on state only, keeping out_ready off the upstream timing path
  assign in_ready = (state != TWO) && !rst;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (push) state_nxt = ONE;
      end
      ONE: begin
        if (push && !pop)      state_nxt = TWO;
        else if (pop && !push) state_nxt = EMPTY;
      end
      TWO: begin
        if (pop) state_nxt = ONE;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    out_valid          = 1'b0;
    count              = 2'd0;
    load_head_new      = 1'b0;
    load_tail_new      = 1'b0;
    load_head_from_tail = 1'b0;
    case (state)
      EMPTY: begin
        load_head_new = push;
      end
      ONE: begin
        out_valid     = 1'b1;
        count         = 2'd1;
        load_head_new = push && pop;
        load_tail_new = push && !pop;
      end
      TWO: begin
        out_valid           = 1'b1;
        count               = 2'd2;
        load_head_from_tail = pop;
      end
      default: begin
        out_valid = 1'b0;
        count     = 2'd0;
      end
    endcase
  end

  // Head only moves on a load, so a stalled head entry stays put
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_p     <= '0;
      head_g_bar <= '1;
      head_c0    <= 1'b0;
      tail_p     <= '0;
      tail_g_bar <= '1;
      tail_c0    <= 1'b0;
    end else begin
      if (load_head_new) begin
        head_p     <= p_new;
        head_g_bar <= g_bar_new;
        head_c0    <= cin;
      end else if (load_head_from_tail) begin
        head_p     <= tail_p;
        head_g_bar <= tail_g_bar;
        head_c0    <= tail_c0;
      end
      if (load_tail_new) begin
        tail_p     <= p_new;
        tail_g_bar <= g_bar_new;
        tail_c0    <= cin;
      end
    end
  end

  assign p     = head_p;
  assign g_bar = head_g_bar;
  assign c0    = head_c0;

endmodule

// File: tb/tb_cla_pg_stage.sv
// tb/tb_cla_pg_stage.sv - directed self-checking bench for cla_pg_stage
module tb_cla_pg_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] a, b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] p, g_bar;
  logic       c0;
  logic [1:0] count;

  int total = 0;
  int bad   = 0;

  cla_pg_stage #(.WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .g_bar(g_bar), .c0(c0), .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [4:0] ep, input logic [4:0] eg, input logic ec);
    chk({tag, ".p"},     {3'b0, p},     {3'b0, ep});
    chk({tag, ".g_bar"}, {3'b0, g_bar}, {3'b0, eg});
    chk({tag, ".c0"},    {7'b0, c0},    {7'b0, ec});
  endtask

  // Reference carry lookahead + sum XOR fed from the stage outputs
  task automatic cla_model(output logic [4:0] sum, output logic cout);
    logic [5:0] c;
    logic [4:0] g;
    g    = ~g_bar;
    c[0] = c0;
    for (int i = 0; i < 5; i++) c[i+1] = g[i] | (p[i] & c[i]);
    sum  = p ^ c[4:0];
    cout = c[5];
  endtask

  logic [4:0] sa [8];
  logic [4:0] sb [8];
  logic       sc [8];
  logic [4:0] sum;
  logic       cout;

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst.out_valid", {7'b0, out_valid}, 8'd0);
    chk("rst.count",     {6'b0, count},     8'd0);
    chk("rst.in_ready",  {7'b0, in_ready},  8'd0);
    chk_head("rst.head", 5'h00, 5'h1F, 1'b0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("post_rst.in_ready", {7'b0, in_ready}, 8'd1);

    // first push
    in_valid = 1'b1; a = 5'h0A; b = 5'h0C; cin = 1'b1;
    step();
    in_valid = 1'b0;
    chk("push1.out_valid", {7'b0, out_valid}, 8'd1);
    chk("push1.count",     {6'b0, count},     8'd1);
    chk_head("push1", 5'h06, 5'h17, 1'b1);

    // drain
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("drain.out_valid", {7'b0, out_valid}, 8'd0);
    chk("drain.count",     {6'b0, count},     8'd0);

    // backpressure: fill both entries
    in_valid = 1'b1; a = 5'h13; b = 5'h0E; cin = 1'b0;
    step();
    chk("bp1.count", {6'b0, count}, 8'd1);
    chk_head("bp1", 5'h1D, 5'h1D, 1'b0);
    a = 5'h1F; b = 5'h01; cin = 1'b0;
    step();
    chk("bp2.count",    {6'b0, count},    8'd2);
    chk("bp2.in_ready", {7'b0, in_ready}, 8'd0);
    chk_head("bp2", 5'h1D, 5'h1D, 1'b0);

    // push attempt while full is ignored
    a = 5'h15; b = 5'h00; cin = 1'b1;
    step();
    chk("full.count", {6'b0, count}, 8'd2);
    chk_head("full", 5'h1D, 5'h1D, 1'b0);

    // one pop: tail moves to head
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pop.count",    {6'b0, count},    8'd1);
    chk("pop.in_ready", {7'b0, in_ready}, 8'd1);
    chk_head("pop", 5'h1E, 5'h1E, 1'b0);

    // end-to-end through the carry model
    cla_model(sum, cout);
    chk("e2e.sum",  {3'b0, sum},  8'h00);
    chk("e2e.cout", {7'b0, cout}, 8'd1);

    // a tail entry pushed while full must not exist: buffer empties after one more pop
    out_ready = 1'b1;
    step();
    chk("pop2.count", {6'b0, count}, 8'd0);

    // streaming at full throughput
    for (int i = 0; i < 8; i++) begin
      sa[i] = 5'($urandom_range(0, 31));
      sb[i] = 5'($urandom_range(0, 31));
      sc[i] = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = sa[i]; b = sb[i]; cin = sc[i];
      step();
      chk($sformatf("stream%0d.count", i), {6'b0, count}, 8'd1);
      chk_head($sformatf("stream%0d", i), sa[i] ^ sb[i], ~(sa[i] & sb[i]), sc[i]);
    end
    in_valid = 1'b0;
    step();
    chk("stream_end.out_valid", {7'b0, out_valid}, 8'd0);

    // asynchronous reset while full
    out_ready = 1'b0;
    in_valid = 1'b1; a = 5'h07; b = 5'h03; cin = 1'b1;
    step();
    a = 5'h11; b = 5'h19;
    step();
    in_valid = 1'b0;
    chk("pre_arst.count", {6'b0, count}, 8'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.out_valid", {7'b0, out_valid}, 8'd0);
    chk("arst.count",     {6'b0, count},     8'd0);
    chk("arst.in_ready",  {7'b0, in_ready},  8'd0);
    chk_head("arst", 5'h00, 5'h1F, 1'b0);
    #3;
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("arst_rel.out_valid", {7'b0, out_valid}, 8'd0);
    chk("arst_rel.in_ready",  {7'b0, in_ready},  8'd1);
    step();
    chk("arst_rel2.count", {6'b0, count}, 8'd0);
    chk_head("arst_rel2", 5'h00, 5'h1F, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
